// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : instruction-fetch request sequencer with variable-latency
//              req/ack memory, stall/flush merge and fetch watchdog.
// Revision   : 1.0
// ============================================================================
module fetch_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  input  logic        PCSrcE,
  input  logic        hz_StallF,
  input  logic        hz_StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        err_o
);

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
  localparam bit               c_wd_en   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      buf_q, buf_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             w_fetch_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      req_addr_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    req_addr_d    = req_addr_q;
    cnt_d         = '0;
    err_d         = err_q;
    imem_req      = 1'b0;
    imem_addr     = PCF;
    InstrF        = '0;
    w_fetch_valid = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_WAIT;

      S_WAIT: begin
        imem_req   = 1'b1;
        InstrF     = imem_rdata;
        req_addr_d = PCF;
        if (imem_ack) begin
          // A redirect in the ack cycle throws the word away; PC already moves.
          if (!PCSrcE) begin
            w_fetch_valid = 1'b1;
            if (hz_StallF) begin
              buf_d   = imem_rdata;
              state_d = S_VALID;
            end
          end
        end else if (PCSrcE) begin
          state_d = S_DRAIN;
        end
      end

      // The abandoned request must still complete at its original address.
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        if (imem_ack) state_d = S_WAIT;
      end

      S_VALID: begin
        InstrF        = buf_q;
        w_fetch_valid = 1'b1;
        if (PCSrcE || !hz_StallF) state_d = S_WAIT;
      end

      default: state_d = S_IDLE;
    endcase

    if (imem_req && !imem_ack)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    if (c_wd_en && (cnt_d == c_timeout))
      err_d = 1'b1;
  end

  assign StallF = !PCSrcE & (hz_StallF | !w_fetch_valid);
  assign FlushD = PCSrcE | (!w_fetch_valid & !hz_StallD);
  assign StallD = hz_StallD & !FlushD;
  assign err_o  = err_q;

endmodule
`default_nettype wire
